// File: rtl/vram_plane_bank.sv
// Bitplane VRAM: PLANES plane RAMs behind a banked CPU port and a double-buffered video shifter.
// Optional macro VRAM_PLANE_CLEAR_EN adds clear_req and a whole-memory clear sequencer.
module vram_plane_ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] craddr_i,
  output logic [DW-1:0] crdata_o,
  input  logic          vre_i,
  input  logic [AW-1:0] vraddr_i,
  output logic [DW-1:0] vrdata_o
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] vrdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (vre_i) vrdata_q <= mem[vraddr_i];
  end

  // CPU side is registered by the top so the read latency stays one cycle.
  assign crdata_o = mem[craddr_i];
  assign vrdata_o = vrdata_q;
endmodule

module vram_plane_bank #(
  parameter int PLANES = 6,
  parameter int AW     = 13,
  parameter int DW     = 8
) (
  input  logic              clk,
  input  logic              reset,
`ifdef VRAM_PLANE_CLEAR_EN
  input  logic              clear_req,
`endif
  input  logic              bank_we,
  input  logic              bank_sel,
  input  logic [7:0]        bank_din,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [DW-1:0]     cpu_din,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DW-1:0]     cpu_dout,
  output logic              cpu_dval,
  input  logic              vid_req,
  input  logic [AW-1:0]     vid_addr,
  output logic              vid_ack,
  input  logic              px_en,
  output logic [PLANES-1:0] vid_bits,
  output logic              underrun,
  output logic              busy
);
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {F_IDLE, F_READ, F_FILL} fst_t;

  logic [7:0]                     rd_bank_q;
  logic [PLANES-1:0]              wr_mask_q;
  logic [DW-1:0]                  cpu_dout_q, cpu_dout_d;
  logic                           cpu_dval_q;
  fst_t                           fst_q, fst_d;
  logic [AW-1:0]                  vaddr_q, vaddr_d;
  logic [PLANES-1:0][DW-1:0]      buf_q, buf_d, sh_q, sh_d, words;
  logic                           buf_full_q, buf_full_d;
  logic [CW-1:0]                  cnt_q, cnt_d, cnt_eff;
  logic [PLANES-1:0]              vid_bits_q, vid_bits_d;
  logic                           underrun_q, underrun_d;
  logic                           vre, fill, xfer, rd_issue, clr_busy;
  logic [PLANES-1:0][DW-1:0]      cpu_rd, vid_rd;
  logic [DW-1:0]                  rd_data;
  logic [PLANES-1:0]              ram_we;
  logic [AW-1:0]                  ram_waddr;
  logic [DW-1:0]                  ram_wdata;

`ifdef VRAM_PLANE_CLEAR_EN
  logic          clr_busy_q;
  logic [AW-1:0] clr_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_busy_q <= 1'b0;
      clr_addr_q <= '0;
    end else if (clear_req) begin
      clr_busy_q <= 1'b1;
      clr_addr_q <= '0;
    end else if (clr_busy_q) begin
      clr_addr_q <= clr_addr_q + AW'(1);
      if (&clr_addr_q) clr_busy_q <= 1'b0;
    end
  end

  assign clr_busy = clr_busy_q;

  // Clear sequencer owns the write port and ignores wr_mask.
  always_comb begin
    ram_we    = (cpu_we && !clr_busy_q) ? wr_mask_q : '0;
    ram_waddr = cpu_addr;
    ram_wdata = cpu_din;
    if (clr_busy_q) begin
      ram_we    = '1;
      ram_waddr = clr_addr_q;
      ram_wdata = '0;
    end
  end
`else
  assign clr_busy  = 1'b0;
  assign ram_we    = cpu_we ? wr_mask_q : '0;
  assign ram_waddr = cpu_addr;
  assign ram_wdata = cpu_din;
`endif

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    vram_plane_ram #(.AW(AW), .DW(DW)) u_ram (
      .clk      (clk),
      .we_i     (ram_we[p]),
      .waddr_i  (ram_waddr),
      .wdata_i  (ram_wdata),
      .craddr_i (cpu_addr),
      .crdata_o (cpu_rd[p]),
      .vre_i    (vre),
      .vraddr_i (vaddr_q),
      .vrdata_o (vid_rd[p])
    );
  end

  // rd_bank k selects plane k-1; anything outside 1..PLANES reads as 0.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < PLANES; p++)
      if (rd_bank_q == 8'(p + 1)) rd_data = cpu_rd[p];
  end

  assign rd_issue   = cpu_re && !cpu_we;
  assign cpu_dout_d = rd_issue ? (clr_busy ? '0 : rd_data) : cpu_dout_q;

  always_comb begin
    fst_d   = fst_q;
    vaddr_d = vaddr_q;
    vid_ack = 1'b0;
    vre     = 1'b0;
    fill    = 1'b0;
    case (fst_q)
      F_IDLE: if (vid_req && !buf_full_q && !clr_busy && !reset) begin
        vid_ack = 1'b1;
        vaddr_d = vid_addr;
        fst_d   = F_READ;
      end
      F_READ: begin
        vre   = 1'b1;
        fst_d = F_FILL;
      end
      F_FILL: begin
        fill  = 1'b1;
        fst_d = F_IDLE;
      end
      default: fst_d = F_IDLE;
    endcase
  end

  // Buffer-to-shifter transfer happens in the same cycle as the shift that needs it.
  always_comb begin
    xfer       = (cnt_q == '0) && buf_full_q;
    words      = xfer ? buf_q : sh_q;
    cnt_eff    = xfer ? CW'(DW) : cnt_q;
    sh_d       = words;
    cnt_d      = cnt_eff;
    vid_bits_d = vid_bits_q;
    underrun_d = underrun_q;
    if (px_en) begin
      if (cnt_eff != '0) begin
        for (int p = 0; p < PLANES; p++) begin
          vid_bits_d[p] = words[p][DW-1];
          sh_d[p]       = words[p] << 1;
        end
        cnt_d = cnt_eff - CW'(1);
      end else begin
        vid_bits_d = '0;
        underrun_d = 1'b1;
      end
    end
    buf_d      = fill ? vid_rd : buf_q;
    buf_full_d = fill ? 1'b1 : (xfer ? 1'b0 : buf_full_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank_q  <= '0;
      wr_mask_q  <= '0;
      cpu_dout_q <= '0;
      cpu_dval_q <= 1'b0;
      fst_q      <= F_IDLE;
      vaddr_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      sh_q       <= '0;
      cnt_q      <= '0;
      vid_bits_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (bank_we && !bank_sel) rd_bank_q <= bank_din;
      if (bank_we && bank_sel)  wr_mask_q <= bank_din[PLANES-1:0];
      cpu_dout_q <= cpu_dout_d;
      cpu_dval_q <= rd_issue;
      fst_q      <= fst_d;
      vaddr_q    <= vaddr_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      vid_bits_q <= vid_bits_d;
      underrun_q <= underrun_d;
    end
  end

  assign cpu_dout = cpu_dout_q;
  assign cpu_dval = cpu_dval_q;
  assign vid_bits = vid_bits_q;
  assign underrun = underrun_q;
  assign busy     = clr_busy;
endmodule

// File: tb/tb_vram_plane_bank.sv
// Directed + randomized bench for vram_plane_bank against a plain array/bit-stream model.
module tb_vram_plane_bank;
  localparam int PLANES = 6;
  localparam int AW     = 13;
  localparam int DW     = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              clear_req;
  logic              bank_we, bank_sel;
  logic [7:0]        bank_din;
  logic [AW-1:0]     cpu_addr, vid_addr;
  logic [DW-1:0]     cpu_din, cpu_dout;
  logic              cpu_we, cpu_re, cpu_dval, vid_req, vid_ack, px_en, underrun, busy;
  logic [PLANES-1:0] vid_bits;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0]     mdl [PLANES][1<<AW];
  logic [7:0]        m_bank;
  logic [PLANES-1:0] m_mask;

  always #5 clk = ~clk;

  vram_plane_bank #(.PLANES(PLANES), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
`ifdef VRAM_PLANE_CLEAR_EN
    .clear_req(clear_req),
`endif
    .bank_we(bank_we), .bank_sel(bank_sel), .bank_din(bank_din),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_dout(cpu_dout), .cpu_dval(cpu_dval),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .px_en(px_en), .vid_bits(vid_bits), .underrun(underrun), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input logic sel, input logic [7:0] v);
    bank_we = 1'b1; bank_sel = sel; bank_din = v;
    tick();
    bank_we = 1'b0;
    if (sel) m_mask = v[PLANES-1:0];
    else     m_bank = v;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_addr = a; cpu_din = d; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    for (int p = 0; p < PLANES; p++) if (m_mask[p]) mdl[p][a] = d;
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (m_bank >= 8'd1 && m_bank <= 8'(PLANES)) return mdl[m_bank-1][a];
    return '0;
  endfunction

  task automatic cpu_rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    cpu_addr = a; cpu_re = 1'b1;
    tick();
    cpu_re = 1'b0;
    chk({tag, "_dval"}, 32'(cpu_dval), 32'd1);
    chk(tag, 32'(cpu_dout), 32'(exp));
    tick();
    chk({tag, "_pulse"}, 32'(cpu_dval), 32'd0);
  endtask

  function automatic logic [PLANES-1:0] m_pixel(input logic [AW-1:0] a, input int idx);
    logic [PLANES-1:0] px;
    for (int p = 0; p < PLANES; p++) px[p] = mdl[p][a][DW-1-idx];
    return px;
  endfunction

  task automatic fetch(input string tag, input logic [AW-1:0] a);
    logic ok;
    ok = 1'b0;
    vid_req = 1'b1; vid_addr = a;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (vid_ack) ok = 1'b1;
      tick();
      if (ok) break;
    end
    vid_req = 1'b0;
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    logic ack2;
    int n;
    reset = 1'b1; clear_req = 1'b0; bank_we = 1'b0; bank_sel = 1'b0; bank_din = '0;
    cpu_addr = '0; cpu_din = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    vid_req = 1'b0; vid_addr = '0; px_en = 1'b0;
    m_bank = '0; m_mask = '0;
    tick(); tick();
    vid_req = 1'b1;
    #1;
    chk("rst_vid_ack", 32'(vid_ack), 32'd0);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    chk("rst_cpu_dval", 32'(cpu_dval), 32'd0);
    chk("rst_vid_bits", 32'(vid_bits), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    vid_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Broadcast write through mask 0x05
    set_bank(1'b1, 8'h3F); cpu_wr(13'h0100, 8'h00);
    set_bank(1'b1, 8'h05); cpu_wr(13'h0100, 8'hA5);
    set_bank(1'b0, 8'd1); cpu_rd("bc_bank1", 13'h0100, 8'hA5);
    set_bank(1'b0, 8'd2); cpu_rd("bc_bank2", 13'h0100, 8'h00);
    set_bank(1'b0, 8'd3); cpu_rd("bc_bank3", 13'h0100, 8'hA5);
    set_bank(1'b0, 8'd0); cpu_rd("bank0_none", 13'h0100, 8'h00);
    set_bank(1'b0, 8'd7); cpu_rd("bank7_none", 13'h0100, 8'h00);

    // Mask 0 drops the write; write beats a simultaneous read
    set_bank(1'b1, 8'h00); cpu_wr(13'h0100, 8'hEE);
    set_bank(1'b0, 8'd1); cpu_rd("mask0_drop", 13'h0100, 8'hA5);
    set_bank(1'b1, 8'h3F);
    cpu_addr = 13'h0100; cpu_din = 8'h3C; cpu_we = 1'b1; cpu_re = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_re = 1'b0;
    for (int p = 0; p < PLANES; p++) mdl[p][13'h0100] = 8'h3C;
    chk("we_re_no_dval", 32'(cpu_dval), 32'd0);
    cpu_rd("we_re_data", 13'h0100, 8'h3C);

    // Randomized CPU traffic over a pre-initialised window
    for (int a = 'h20; a < 'h30; a++) cpu_wr(AW'(a), 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: set_bank(1'b1, 8'($urandom));
        1: cpu_wr(AW'($urandom_range('h20, 'h2F)), 8'($urandom));
        default: begin
          logic [AW-1:0] a;
          a = AW'($urandom_range('h20, 'h2F));
          set_bank(1'b0, 8'($urandom_range(0, 8)));
          cpu_rd("rand_rd", a, m_read(a));
        end
      endcase
    end

    // Directed pixel stream
    set_bank(1'b1, 8'h3F); cpu_wr(13'h0010, 8'h00);
    set_bank(1'b1, 8'h01); cpu_wr(13'h0010, 8'h80);
    set_bank(1'b1, 8'h02); cpu_wr(13'h0010, 8'h01);
    fetch("px_ack", 13'h0010);
    tick(); tick();
    for (int i = 0; i < DW; i++) begin
      px_en = 1'b1;
      tick();
      chk("px_dir", 32'(vid_bits), 32'(m_pixel(13'h0010, i)));
    end
    px_en = 1'b0;
    chk("px_dir_underrun", 32'(underrun), 32'd0);

    // Continuous two-word stream with random plane data
    for (int p = 0; p < PLANES; p++) begin
      set_bank(1'b1, 8'(1 << p));
      cpu_wr(13'h0010, 8'($urandom));
      cpu_wr(13'h0011, 8'($urandom));
    end
    fetch("cont_ack1", 13'h0010);
    ack2 = 1'b0;
    for (int c = 0; c < 22; c++) begin
      vid_req = !ack2; vid_addr = 13'h0011;
      px_en = (c >= 2 && c < 18);
      #1;
      if (vid_req && vid_ack) ack2 = 1'b1;
      tick();
      if (px_en) begin
        if (c < 10) chk("cont_px0", 32'(vid_bits), 32'(m_pixel(13'h0010, c - 2)));
        else        chk("cont_px1", 32'(vid_bits), 32'(m_pixel(13'h0011, c - 10)));
      end
    end
    vid_req = 1'b0; px_en = 1'b0;
    chk("cont_ack2", 32'(ack2), 32'd1);
    chk("cont_underrun", 32'(underrun), 32'd0);

    // Starvation on the ninth pixel, sticky until reset
    fetch("starve_ack", 13'h0011);
    tick(); tick();
    for (int i = 0; i < DW; i++) begin
      px_en = 1'b1;
      tick();
    end
    chk("starve_last_px", 32'(vid_bits), 32'(m_pixel(13'h0011, DW - 1)));
    chk("starve_pre", 32'(underrun), 32'd0);
    tick();
    px_en = 1'b0;
    chk("starve_bits", 32'(vid_bits), 32'd0);
    chk("starve_flag", 32'(underrun), 32'd1);
    tick(); tick(); tick();
    chk("starve_sticky", 32'(underrun), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_bank = '0; m_mask = '0;
    chk("starve_reset", 32'(underrun), 32'd0);

`ifdef VRAM_PLANE_CLEAR_EN
    set_bank(1'b1, 8'h3F);
    cpu_wr(13'h0000, 8'h55); cpu_wr(13'h0100, 8'h55); cpu_wr(13'h1FFF, 8'h55);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    chk("clr_busy_start", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < (1 << AW) + 20) begin
      cpu_we = (n == 3); cpu_addr = (n == 10) ? 13'h0100 : 13'h0000; cpu_din = 8'hFF;
      cpu_re = (n == 10);
      tick();
      n++;
      if (n == 11) begin
        chk("clr_rd_dval", 32'(cpu_dval), 32'd1);
        chk("clr_rd_zero", 32'(cpu_dout), 32'd0);
      end
    end
    cpu_we = 1'b0; cpu_re = 1'b0;
    chk("clr_busy_len", 32'(n), 32'(1 << AW));
    for (int p = 0; p < PLANES; p++)
      for (int a = 0; a < (1 << AW); a++) mdl[p][a] = '0;
    for (int p = 1; p <= PLANES; p++) begin
      set_bank(1'b0, 8'(p));
      cpu_rd("clr_zero_lo", 13'h0000, 8'h00);
      cpu_rd("clr_zero_mid", 13'h0100, 8'h00);
      cpu_rd("clr_zero_hi", 13'h1FFF, 8'h00);
    end
`else
    n = 0;
    repeat (4) begin
      tick();
      if (busy !== 1'b0) n++;
    end
    chk("busy_tied_low", 32'(n), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vram_plane_bank.md
Name: vram_plane_bank

Overview:
- Parametrised bitplane VRAM block for the RX-78 core and later plane-based video cores.
- Holds PLANES independent 2^AW x DW plane RAMs.
- CPU port: bank-register read selection, plus a write mask that broadcasts one write to several planes.
- Video port: a double-buffered fetch/shift pipeline that delivers one bit per plane per pixel strobe. This replaces ad-hoc per-plane muxing in the top level.

Parameters:
- PLANES, 6, number of bitplanes (1..8).
- AW, 13, plane address width.
- DW, 8, plane data width; also the pixels per fetched word.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- bank_we  in  1  one-cycle strobe, write bank register.
- bank_sel  in  1  0 = read-bank register, 1 = write-mask register.
- bank_din  in  8  bank register data.
- cpu_addr  in  AW  CPU plane address.
- cpu_din  in  DW  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_re  in  1  CPU read strobe.
- cpu_dout  out  DW  CPU read data.
- cpu_dval  out  1  cpu_dout valid pulse.
- vid_req  in  1  request fetch of vid_addr.
- vid_addr  in  AW  video fetch address.
- vid_ack  out  1  request accepted.
- px_en  in  1  pixel strobe, shift one pixel.
- vid_bits  out  PLANES  current pixel, bit p from plane p.
- underrun  out  1  sticky, shifter starved.
- busy  out  1  clear sequencer active (0 when feature compiled out).

Behaviour:
- Reset values: rd_bank=0, wr_mask=0, cpu_dout=0, cpu_dval=0, vid_ack=0, vid_bits=0, underrun=0, busy=0. Shifter and prefetch buffer are marked empty. RAM contents are not reset.
- Bank registers:
  - bank_sel=0 loads rd_bank (8 bits). Value k in 1..PLANES selects plane k-1; any other value selects no plane.
  - bank_sel=1 loads wr_mask[PLANES-1:0]; upper bits are ignored.
  - The new value is used from the next cycle.
- CPU write: cpu_we writes cpu_din at cpu_addr into every plane p with wr_mask[p]=1. With mask 0 the write is dropped.
- CPU read:
  - cpu_re -> cpu_dout and cpu_dval=1 exactly one cycle later.
  - Data is the selected plane, or 0 if no plane is selected.
  - cpu_dval is a single-cycle pulse.
  - cpu_we and cpu_re in the same cycle: the write wins and no read is issued.
- Video fetch path:
  - Holds a prefetch buffer (PLANES x DW) and a shifter (PLANES x DW plus a bit counter 0..DW).
  - Fetch FSM: IDLE -> READ -> FILL -> IDLE.
  - IDLE: on vid_req while the buffer is empty, latch vid_addr, pulse vid_ack, go to READ. vid_req while the buffer is full is held off (no ack).
  - READ: RAM latency cycle.
  - FILL: store all planes into the buffer, mark it full, go to IDLE.
  - The video port is a separate read port per plane and never conflicts with the CPU.
- Shifter:
  - On px_en, vid_bits is driven from the MSB of each plane word and the words shift left; the counter decrements.
  - When the counter is 0 and the buffer is full, the buffer transfers into the shifter (counter=DW) in the same cycle, and the buffer becomes empty.
  - Transfer and the first shift coincide if px_en is high: no bubble.
  - px_en with the counter 0 and the buffer empty gives vid_bits=0 and sets underrun, which stays set until reset.
  - A FILL and a transfer in the same cycle are allowed; the new data lands in the buffer after the transfer empties it.
- Reset mid-fetch: the FSM returns to IDLE and fetched data is discarded.

Optional Feature:
- Macro VRAM_PLANE_CLEAR_EN adds input clear_req (1 bit).
- With the macro:
  - clear_req sets busy=1 and starts an address counter from 0.
  - Each cycle writes 0 to that address in all planes, regardless of wr_mask, and increments the counter.
  - After address 2^AW-1, busy drops the next cycle.
  - While busy: CPU writes are dropped, CPU reads return 0 with cpu_dval, and vid_req is not acked.
  - clear_req while busy restarts the counter at 0.
- Without the macro: no clear_req port, busy tied to 0.

Test Plan:
- Broadcast write: wr_mask=0x05, write 0xA5 @0x0100; set rd_bank=1,2,3 and read -> 0xA5, 0x00, 0xA5, each with cpu_dval one cycle after cpu_re.
- Read invalid bank: rd_bank=0 and rd_bank=7 with data present -> cpu_dout=0x00.
- Pixel stream: plane0 @0x10=0x80, plane1 @0x10=0x01; vid_req @0x10, then 8 px_en -> vid_bits = 0b01 first pixel, 0b00 for pixels 2-7, 0b10 last.
- Continuous stream: back-to-back requests for 0x10 and 0x11 with px_en held high for 16 cycles -> 16 pixels, no gap, underrun=0.
- Starvation: one fetch, then 9 px_en -> 9th pixel vid_bits=0, underrun=1 sticky until reset.
- Clear (VRAM_PLANE_CLEAR_EN): fill planes, pulse clear_req -> busy high for exactly 2^AW cycles; a CPU write during busy is ignored; after busy drops, every plane reads 0x00.
